// File: rtl/inc_unit.sv
// inc_unit: 16-bit address incrementer with its Inc result register.
// Samples the address bus on a request, waits a modelled relay-settling
// delay, then writes sample+1 into the Inc register and pulses done.
module inc_unit #(
    parameter int ADDR_W        = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ld_inc,
    input  logic              sel_inc,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_oe,
    output logic              busy,
    output logic              done,
    output logic              carry,
    output logic              led_ld_inc,
    output logic              led_sel_inc
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Counter starts at SETTLE_CYCLES-1 so the write lands exactly
    // SETTLE_CYCLES edges after the accepting edge.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   inc_q;
    logic [ADDR_W-1:0]   sample_q;
    logic [3:0]          cnt_q;
    logic                done_q;
    logic                carry_q;
    logic [ADDR_W:0]     sum_d;

    // Widened sum: the extra top bit is the wrap from all-ones to zero.
    assign sum_d = {1'b0, sample_q} + {{ADDR_W{1'b0}}, 1'b1};

    // Request/settle sequencer; done and carry are registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            inc_q    <= '0;
            sample_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_inc) begin
                        sample_q <= addr_in;
                        cnt_q    <= CNT_INIT;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Requests arriving here are dropped, not queued.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        inc_q   <= sum_d[ADDR_W-1:0];
                        carry_q <= sum_d[ADDR_W];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus drive and LED mirrors are purely combinational; during SETTLE the
    // bus still shows the previous Inc value.
    always_comb begin
        addr_out    = sel_inc ? inc_q : '0;
        addr_oe     = sel_inc;
        led_ld_inc  = ld_inc;
        led_sel_inc = sel_inc;
    end

    assign busy  = (state_q == SETTLE);
    assign done  = done_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_inc_unit.sv
// tb_inc_unit: directed self-checking bench for inc_unit (SETTLE_CYCLES=4).
module tb_inc_unit;

    localparam int AW = 16;
    localparam int SC = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] addr_in;
    logic          ld_inc;
    logic          sel_inc;
    logic [AW-1:0] addr_out;
    logic          addr_oe;
    logic          busy;
    logic          done;
    logic          carry;
    logic          led_ld_inc;
    logic          led_sel_inc;

    int checks;
    int errors;

    inc_unit #(.ADDR_W(AW), .SETTLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_in     (addr_in),
        .ld_inc      (ld_inc),
        .sel_inc     (sel_inc),
        .addr_out    (addr_out),
        .addr_oe     (addr_oe),
        .busy        (busy),
        .done        (done),
        .carry       (carry),
        .led_ld_inc  (led_ld_inc),
        .led_sel_inc (led_sel_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns just after the completion edge.
    task automatic run_inc(input logic [AW-1:0] a);
        addr_in = a;
        ld_inc  = 1'b1;
        tick();
        ld_inc  = 1'b0;
        repeat (SC) tick();
    endtask

    task automatic test_reset();
        sel_inc = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (addr_out !== 16'h0000) begin errors++; $display("FAIL reset_addr_out got %h expected 0000", addr_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b expected 0", carry); end
        checks++;
        if (addr_oe !== 1'b1) begin errors++; $display("FAIL reset_addr_oe got %b expected 1", addr_oe); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        addr_in = 16'h1234;
        ld_inc  = 1'b1;
        #1;
        checks++;
        if (led_ld_inc !== 1'b1) begin errors++; $display("FAIL led_ld_inc got %b expected 1", led_ld_inc); end
        tick();
        ld_inc = 1'b0;
        #1;
        checks++;
        if (led_ld_inc !== 1'b0) begin errors++; $display("FAIL led_ld_inc_low got %b expected 0", led_ld_inc); end
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL basic_settle[%0d] got busy=%b done=%b expected busy=1 done=0", i, busy, done);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL basic_done got busy=%b done=%b expected busy=0 done=1", busy, done);
        end
        checks++;
        if (addr_out !== 16'h1235 || carry !== 1'b0) begin
            errors++; $display("FAIL basic_result got %h carry=%b expected 1235 carry=0", addr_out, carry);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_wrap();
        run_inc(16'hFFFF);
        checks++;
        if (addr_out !== 16'h0000 || carry !== 1'b1) begin
            errors++; $display("FAIL wrap_result got %h carry=%b expected 0000 carry=1", addr_out, carry);
        end
        tick();
        checks++;
        if (carry !== 1'b1) begin errors++; $display("FAIL wrap_carry_sticky got %b expected 1", carry); end
        run_inc(16'h0010);
        checks++;
        if (addr_out !== 16'h0011 || carry !== 1'b0) begin
            errors++; $display("FAIL wrap_next got %h carry=%b expected 0011 carry=0", addr_out, carry);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ndone;
        // Second request at E2 must be dropped.
        addr_in = 16'h0100;
        ld_inc  = 1'b1;
        tick();
        ld_inc  = 1'b0;
        ndone   = (done === 1'b1) ? 1 : 0;
        tick();
        addr_in = 16'h0200;
        ld_inc  = 1'b1;
        tick();
        ld_inc  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL busy_req_done_count got %0d expected 1", ndone); end
        checks++;
        if (addr_out !== 16'h0101) begin errors++; $display("FAIL busy_req_result got %h expected 0101", addr_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_req_idle got %b expected 0", busy); end

        // Held request: accepted at E0, next acceptance at E5.
        addr_in = 16'h0300;
        ld_inc  = 1'b1;
        tick();
        addr_in = 16'h0400;
        repeat (SC - 1) tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || addr_out !== 16'h0301) begin
            errors++; $display("FAIL held_first got busy=%b done=%b out=%h expected busy=0 done=1 out=0301", busy, done, addr_out);
        end
        tick();
        ld_inc = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL held_second_accept got busy=%b expected 1", busy); end
        repeat (SC) tick();
        checks++;
        if (done !== 1'b1 || addr_out !== 16'h0401) begin
            errors++; $display("FAIL held_second_result got done=%b out=%h expected done=1 out=0401", done, addr_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int ndone;
        addr_in = 16'h00FF;
        ld_inc  = 1'b1;
        tick();
        ld_inc  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || addr_out !== 16'h0000) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b out=%h expected busy=0 done=0 out=0000", busy, done, addr_out);
        end
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles expected 0", ndone); end
        run_inc(16'h00FF);
        checks++;
        if (done !== 1'b1 || addr_out !== 16'h0100 || carry !== 1'b0) begin
            errors++; $display("FAIL reset_mid_fresh got done=%b out=%h carry=%b expected done=1 out=0100 carry=0", done, addr_out, carry);
        end
        tick();
    endtask

    task automatic test_bus_settle();
        run_inc(16'h0041);
        tick();
        sel_inc = 1'b1;
        addr_in = 16'h0A00;
        ld_inc  = 1'b1;
        tick();
        ld_inc  = 1'b0;
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (addr_out !== 16'h0042 || addr_oe !== 1'b1 || led_sel_inc !== 1'b1) begin
                errors++; $display("FAIL bus_settle[%0d] got out=%h oe=%b led=%b expected out=0042 oe=1 led=1", i, addr_out, addr_oe, led_sel_inc);
            end
            tick();
        end
        checks++;
        if (addr_out !== 16'h0A01) begin errors++; $display("FAIL bus_settle_result got %h expected 0A01", addr_out); end
        sel_inc = 1'b0;
        #1;
        checks++;
        if (addr_out !== 16'h0000 || addr_oe !== 1'b0 || led_sel_inc !== 1'b0) begin
            errors++; $display("FAIL bus_deselect got out=%h oe=%b led=%b expected out=0000 oe=0 led=0", addr_out, addr_oe, led_sel_inc);
        end
        sel_inc = 1'b1;
        #1;
        checks++;
        if (addr_out !== 16'h0A01 || addr_oe !== 1'b1) begin
            errors++; $display("FAIL bus_reselect got out=%h oe=%b expected out=0A01 oe=1", addr_out, addr_oe);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        addr_in = '0;
        ld_inc  = 1'b0;
        sel_inc = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_bus_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
